// File: rtl/if_stage_ctrl.sv
// -----------------------------------------------------------------------------
// if_stage_ctrl
//   Fetch-side controller. Owns the PC register and the IF/ID pipeline register.
//   It responds to hazard-unit holds (pc_write_i / if_id_write_i) and to
//   redirects resolved in ID (taken branch / jump / jr). It optionally squashes
//   the instruction after a branch. It also counts stalled cycles and raises a
//   sticky watchdog flag when a hold runs too long.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   DELAY_SLOT   1: the instruction after a branch executes; 0: it becomes a bubble
//   STALL_CNT_W  width of the saturating stall-cycle counter
//   MAX_STALL    consecutive held cycles allowed before stall_timeout_o sets
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   reset_i          synchronous, active-high reset
//   pc_write_i       0 = hold the PC
//   if_id_write_i    0 = hold the IF/ID register
//   redirect_i       taken branch / jump / jr resolved in ID this cycle
//   redirect_pc_i    redirect target
//   imem_rdata_i     instruction at imem_addr_o (combinational read)
//   imem_addr_o      current PC
//   if_id_instr_o    IF/ID instruction (32'h0 = bubble)
//   if_id_pc4_o      IF/ID PC+4 of the held instruction
//   if_id_valid_o    IF/ID holds a real instruction
//   stall_cycles_o   saturating count of cycles with pc_write_i = 0
//   stall_timeout_o  sticky; a hold exceeded MAX_STALL consecutive cycles
// -----------------------------------------------------------------------------
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          DELAY_SLOT  = 1'b1,
  parameter int          STALL_CNT_W = 16,
  parameter int          MAX_STALL   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pc_write_i,
  input  logic                   if_id_write_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  input  logic [31:0]            imem_rdata_i,
  output logic [31:0]            imem_addr_o,
  output logic [31:0]            if_id_instr_o,
  output logic [31:0]            if_id_pc4_o,
  output logic                   if_id_valid_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   stall_timeout_o
);

  localparam int HR_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [HR_W-1:0] HR_MAX = HR_W'(MAX_STALL);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            pc4_q, pc4_d;
  logic                   valid_q, valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [HR_W-1:0]        hold_run_q, hold_run_d;
  logic                   timeout_q, timeout_d;

  logic [31:0] pc_plus4;
  logic        squash_now;

  // 32-bit modulo add: 32'hFFFF_FFFC wraps to 0 with no flag.
  assign pc_plus4   = pc_q + 32'd4;
  // A redirect counts only when the PC may move. While the PC is held, the
  // branch operands are not resolved yet, and the redirect re-asserts later.
  assign squash_now = redirect_i && pc_write_i && !DELAY_SLOT;

  // FSM next state.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH, HOLD, SQUASH: begin
        // SQUASH lasts one cycle and then decides exactly as FETCH does.
        if (!pc_write_i)     state_d = HOLD;
        else if (squash_now) state_d = SQUASH;
        else                 state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Datapath next state.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    stall_d    = stall_q;
    hold_run_d = hold_run_q;
    timeout_d  = timeout_q;

    if (pc_write_i) begin
      pc_d = redirect_i ? redirect_pc_i : pc_plus4;
    end

    if (if_id_write_i) begin
      if (squash_now) begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_rdata_i;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end

    if (!pc_write_i) begin
      if (stall_q != '1) stall_d = stall_q + 1'b1;
      // Once the run has reached MAX_STALL, one more held cycle sets the flag.
      if (hold_run_q == HR_MAX) timeout_d  = 1'b1;
      else                      hold_run_d = hold_run_q + 1'b1;
    end else begin
      hold_run_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc4_q      <= 32'h0;
      valid_q    <= 1'b0;
      stall_q    <= '0;
      hold_run_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      hold_run_q <= hold_run_d;
      timeout_q  <= timeout_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign if_id_instr_o   = instr_q;
  assign if_id_pc4_o     = pc4_q;
  assign if_id_valid_o   = valid_q;
  assign stall_cycles_o  = stall_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
module tb_if_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        redirect;
  logic [31:0] redirect_pc;

  // DUT with a delay slot (default parameters).
  logic [31:0] a_addr, a_rdata, a_instr, a_pc4;
  logic        a_valid, a_tmo;
  logic [15:0] a_stall;

  // DUT without a delay slot and with a narrow stall counter, used for saturation.
  logic [31:0] b_addr, b_rdata, b_instr, b_pc4;
  logic        b_valid, b_tmo;
  logic [2:0]  b_stall;

  int errors = 0;
  int checks = 0;

  // Instruction memory model: a nonzero word derived from the address.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'hA000_0000 ^ addr;
  endfunction

  assign a_rdata = imem(a_addr);
  assign b_rdata = imem(b_addr);

  if_stage_ctrl u_ds1 (
    .clk_i(clk), .reset_i(reset), .pc_write_i(pc_write), .if_id_write_i(if_id_write),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .imem_rdata_i(a_rdata),
    .imem_addr_o(a_addr), .if_id_instr_o(a_instr), .if_id_pc4_o(a_pc4),
    .if_id_valid_o(a_valid), .stall_cycles_o(a_stall), .stall_timeout_o(a_tmo)
  );

  if_stage_ctrl #(.DELAY_SLOT(1'b0), .STALL_CNT_W(3)) u_ds0 (
    .clk_i(clk), .reset_i(reset), .pc_write_i(pc_write), .if_id_write_i(if_id_write),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .imem_rdata_i(b_rdata),
    .imem_addr_o(b_addr), .if_id_instr_o(b_instr), .if_id_pc4_o(b_pc4),
    .if_id_valid_o(b_valid), .stall_cycles_o(b_stall), .stall_timeout_o(b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the IF/ID fields and the PC of one DUT.
  task automatic chk_a(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid);
    check({tag, ".a.addr"},  a_addr,  addr);
    check({tag, ".a.instr"}, a_instr, instr);
    check({tag, ".a.pc4"},   a_pc4,   pc4);
    check({tag, ".a.valid"}, 32'(a_valid), 32'(valid));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid);
    check({tag, ".b.addr"},  b_addr,  addr);
    check({tag, ".b.instr"}, b_instr, instr);
    check({tag, ".b.pc4"},   b_pc4,   pc4);
    check({tag, ".b.valid"}, 32'(b_valid), 32'(valid));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_a(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    chk_b(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    check({tag, ".a.stall"}, 32'(a_stall), 32'd0);
    check({tag, ".b.stall"}, 32'(b_stall), 32'd0);
    check({tag, ".a.tmo"},   32'(a_tmo),   32'd0);
    check({tag, ".b.tmo"},   32'(b_tmo),   32'd0);
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    #1;

    // T1: reset for two cycles, then straight-line fetch.
    step(); step();
    chk_reset_state("rst");
    reset = 1'b0;
    step();
    chk_a("t1.c1", 32'h4, imem(32'h0), 32'h4, 1'b1);
    step();
    chk_a("t1.c2", 32'h8, imem(32'h4), 32'h8, 1'b1);
    step();
    chk_a("t1.c3", 32'hC, imem(32'h8), 32'hC, 1'b1);
    chk_b("t1.c3", 32'hC, imem(32'h8), 32'hC, 1'b1);

    // T2: two-cycle hold at pc=0xC, then resume.
    pc_write = 1'b0; if_id_write = 1'b0;
    step(); step();
    chk_a("t2.hold", 32'hC, imem(32'h8), 32'hC, 1'b1);
    check("t2.a.stall", 32'(a_stall), 32'd2);
    check("t2.a.tmo",   32'(a_tmo),   32'd0);
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    chk_a("t2.resume", 32'h10, imem(32'hC), 32'h10, 1'b1);
    check("t2.a.stall_kept", 32'(a_stall), 32'd2);

    // T3/T4: redirect to 0x40 at pc=0x10.
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk_b("t3.bubble", 32'h40, 32'h0, 32'h0, 1'b0);
    chk_a("t4.slot",   32'h40, imem(32'h10), 32'h14, 1'b1);
    redirect = 1'b0;
    step();
    chk_b("t3.target", 32'h44, imem(32'h40), 32'h44, 1'b1);
    chk_a("t4.target", 32'h44, imem(32'h40), 32'h44, 1'b1);

    // T5: redirect while held is ignored; five held cycles trip the watchdog.
    pc_write = 1'b0; if_id_write = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 4; i++) step();
    chk_a("t5.held4", 32'h44, imem(32'h40), 32'h44, 1'b1);
    check("t5.a.tmo4",   32'(a_tmo),   32'd0);
    check("t5.a.stall4", 32'(a_stall), 32'd6);
    step();
    check("t5.a.tmo5",   32'(a_tmo),   32'd1);
    check("t5.b.tmo5",   32'(b_tmo),   32'd1);
    check("t5.a.stall5", 32'(a_stall), 32'd7);
    check("t5.b.stall5", 32'(b_stall), 32'd7);
    check("t5.b.addr",   b_addr,       32'h44);
    pc_write = 1'b1; if_id_write = 1'b1; redirect = 1'b0;
    step();
    chk_a("t5.release", 32'h48, imem(32'h44), 32'h48, 1'b1);
    check("t5.a.tmo_sticky", 32'(a_tmo), 32'd1);

    // PC advances while IF/ID holds.
    if_id_write = 1'b0;
    step();
    chk_a("mix", 32'h4C, imem(32'h44), 32'h48, 1'b1);
    if_id_write = 1'b1;

    // T6: stall counter saturation, then reset during HOLD.
    pc_write = 1'b0;
    step();
    check("t6.b.stall_sat", 32'(b_stall), 32'd7);
    check("t6.a.stall8",    32'(a_stall), 32'd8);
    reset = 1'b1;
    step();
    chk_reset_state("t6.rst_hold");

    // Reset during SQUASH.
    reset = 1'b0; pc_write = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk_b("t6.squash", 32'h100, 32'h0, 32'h0, 1'b0);
    reset = 1'b1; redirect = 1'b0;
    step();
    chk_reset_state("t6.rst_squash");

    // PC wraps from 0xFFFF_FFFC to 0.
    reset = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    check("t6.a.addr_top", a_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk_a("t6.wrap", 32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
